// File: rtl/klein_encrypt_if.sv
// Start/key/plaintext request and ciphertext/status response of the KLEIN-64 encryption core.
interface klein_encrypt_if;
  logic        istart;
  logic [0:63] ikey;
  logic [0:63] idata;
  logic [0:63] odata;
  logic        obusy;
  logic        odone;

  modport master (output istart, ikey, idata, input odata, obusy, odone);
  modport slave  (input istart, ikey, idata, output odata, obusy, odone);
endinterface

// File: rtl/klein_encrypt.sv
// Iterative KLEIN-64 encryption: one round plus one key-schedule step per clock,
// with final whitening by the 13th subkey.

module klein_sbox (
  input  logic [3:0] a,
  output logic [3:0] y
);
  always_comb begin
    case (a)
      4'h0: y = 4'h7;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'h9;
      4'h4: y = 4'h1;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h0;
      4'h8: y = 4'hC;  4'h9: y = 4'h3;  4'hA: y = 4'h2;  4'hB: y = 4'h6;
      4'hC: y = 4'h8;  4'hD: y = 4'hE;  4'hE: y = 4'hD;  4'hF: y = 4'h5;
      default: y = 4'h0;
    endcase
  end
endmodule

module klein_encrypt #(
  parameter int NROUNDS = 12
) (
  input logic            iclk,
  input logic            ireset,
  klein_encrypt_if.slave bus
);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t        fsm_q, fsm_n;
  logic [0:63] state_q, state_n;
  logic [0:63] sk_q, sk_n;
  logic [0:63] odata_q, odata_n;
  logic [3:0]  round_q, round_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // AES MixColumns on one 4-byte column, written as t ^ b_i ^ 2*(b_i ^ b_i+1).
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3, t;
    b0 = c[31:24];
    b1 = c[23:16];
    b2 = c[15:8];
    b3 = c[7:0];
    t  = b0 ^ b1 ^ b2 ^ b3;
    return {b0 ^ t ^ xtime(b0 ^ b1), b1 ^ t ^ xtime(b1 ^ b2),
            b2 ^ t ^ xtime(b2 ^ b3), b3 ^ t ^ xtime(b3 ^ b0)};
  endfunction

  // Round data path.
  logic [0:63] ark, sub, rot, mix;

  assign ark = state_q ^ sk_q;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    klein_sbox u_sbox (.a(ark[4*i +: 4]), .y(sub[4*i +: 4]));
  end

  assign rot = {sub[16:63], sub[0:15]};
  assign mix = {mix_col(rot[0:31]), mix_col(rot[32:63])};

  // Key-schedule step KS(sk_q, round_q), running in lock-step with the round.
  logic [0:31] ka, kb;
  logic [0:63] ks_rc, ks_out;
  logic [0:15] ks_sub;

  assign ka    = {sk_q[8:31], sk_q[0:7]};
  assign kb    = {sk_q[40:63], sk_q[32:39]};
  assign ks_rc = {kb, ka ^ kb} ^ {16'h0000, 4'h0, round_q, 40'h00_0000_0000};

  for (genvar j = 0; j < 4; j++) begin : g_ks_sub
    klein_sbox u_sbox (.a(ks_rc[40 + 4*j +: 4]), .y(ks_sub[4*j +: 4]));
  end

  assign ks_out = {ks_rc[0:39], ks_sub, ks_rc[56:63]};

  // NOTE: every variable is given a default before the case so no path can leave it unassigned (no latches).
  always_comb begin
    fsm_n   = fsm_q;
    state_n = state_q;
    sk_n    = sk_q;
    round_n = round_q;
    odata_n = odata_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.istart) begin
          state_n = bus.idata;
          sk_n    = bus.ikey;
          round_n = 4'd1;
          busy_n  = 1'b1;
          fsm_n   = RUN;
        end
      end
      RUN: begin
        state_n = mix;
        sk_n    = ks_out;
        round_n = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          odata_n = mix ^ ks_out;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          fsm_n   = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      sk_q    <= '0;
      odata_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_n;
      state_q <= state_n;
      sk_q    <= sk_n;
      odata_q <= odata_n;
      round_q <= round_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.odata = odata_q;
  assign bus.obusy = busy_q;
  assign bus.odone = done_q;
endmodule

// File: tb/tb_klein_encrypt.sv
// Directed-vector bench for klein_encrypt using the published KLEIN-64 test vectors.
module tb_klein_encrypt;
  logic iclk = 1'b0;
  logic ireset = 1'b0;

  klein_encrypt_if bus ();

  klein_encrypt #(.NROUNDS(12)) dut (.iclk(iclk), .ireset(ireset), .bus(bus));

  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] K0 = 64'h0000000000000000;
  localparam logic [63:0] KF = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] K1 = 64'h1234567890ABCDEF;
  localparam logic [63:0] C1 = 64'hCDC0B51F14722BBE;
  localparam logic [63:0] C2 = 64'h6456764E8602E154;
  localparam logic [63:0] C3 = 64'h592356C4997176C8;
  localparam logic [63:0] C4 = 64'h629F9D6DFF95800E;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the following rising edge is the start edge T.
  task automatic start_op(input logic [63:0] key, input logic [63:0] pt);
    bus.istart = 1'b1;
    bus.ikey   = key;
    bus.idata  = pt;
    @(negedge iclk);
    bus.istart = 1'b0;
  endtask

  // Returns at the falling edge where odone is seen; lat counts rising edges after T.
  task automatic wait_done(input logic [63:0] hold, output int lat, output int hold_bad);
    lat = -1;
    hold_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.odone === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (bus.odata !== hold) hold_bad++;
      @(negedge iclk);
    end
  endtask

  task automatic run_vector(input string tag, input logic [63:0] key, input logic [63:0] pt,
                            input logic [63:0] exp);
    logic [63:0] old;
    int lat, bad;
    old = bus.odata;
    start_op(key, pt);
    check({tag, "_busy"}, {63'd0, bus.obusy}, 64'd1);
    wait_done(old, lat, bad);
    check({tag, "_latency"}, 64'(lat), 64'd12);
    check({tag, "_odata"}, bus.odata, exp);
    check({tag, "_hold"}, 64'(bad), 64'd0);
    check({tag, "_busy_end"}, {63'd0, bus.obusy}, 64'd0);
  endtask

  initial begin
    int dones, done_at;
    bus.istart = 1'b0;
    bus.ikey   = '0;
    bus.idata  = '0;

    // Reset state
    repeat (2) @(negedge iclk);
    check("rst_odata", bus.odata, 64'd0);
    check("rst_busy", {63'd0, bus.obusy}, 64'd0);
    check("rst_done", {63'd0, bus.odone}, 64'd0);
    ireset = 1'b1;
    repeat (2) @(negedge iclk);

    // Vector 1 with single-cycle odone
    run_vector("v1", K0, KF, C1);
    @(negedge iclk);
    check("v1_done_width", {63'd0, bus.odone}, 64'd0);

    run_vector("v2", KF, K0, C2);
    @(negedge iclk);
    run_vector("v3", K1, KF, C3);
    @(negedge iclk);
    run_vector("v4", K0, K1, C4);
    @(negedge iclk);

    // Starts while busy are ignored
    start_op(K0, KF);
    dones = 0;
    done_at = -1;
    for (int k = 1; k <= 18; k++) begin
      if (bus.odone === 1'b1) begin
        dones++;
        done_at = k - 1;
      end
      if (k == 5) check("ign_busy_mid", {63'd0, bus.obusy}, 64'd1);
      if (k == 3 || k == 11) begin
        bus.istart = 1'b1;
        bus.ikey   = K1;
        bus.idata  = K1;
      end else begin
        bus.istart = 1'b0;
      end
      @(negedge iclk);
    end
    check("ign_done_count", 64'(dones), 64'd1);
    check("ign_latency", 64'(done_at), 64'd12);
    check("ign_odata", bus.odata, C1);
    check("ign_idle", {63'd0, bus.obusy}, 64'd0);

    // Asynchronous reset mid-operation
    start_op(KF, K0);
    repeat (5) @(negedge iclk);
    ireset = 1'b0;
    #1;
    check("arst_odata", bus.odata, 64'd0);
    check("arst_busy", {63'd0, bus.obusy}, 64'd0);
    check("arst_done", {63'd0, bus.odone}, 64'd0);
    @(negedge iclk);
    ireset = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.odone === 1'b1) dones++;
      @(negedge iclk);
    end
    check("arst_no_done", 64'(dones), 64'd0);
    run_vector("arst_restart", K1, KF, C3);
    @(negedge iclk);

    // Start issued in the odone cycle
    run_vector("bb1", K0, KF, C1);
    run_vector("bb2", K0, K1, C4);
    @(negedge iclk);
    check("bb2_done_width", {63'd0, bus.odone}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/klein_encrypt.md
Name: klein_encrypt

Overview:
- Iterative KLEIN-64 encryption core. It consumes a 64-bit key and a 64-bit plaintext block and runs one full cipher round per clock.
- The round-key update is the KLEIN key-schedule step, computed inline in lock-step with the data path. It uses the same step as klein_keyschedule, so the 13th subkey equals that block's okey for the same ikey.
- Sits between the bus-side register interface and the result register. It is the data-path consumer of the round keys.

Parameters:
- NROUNDS, 12, number of cipher rounds. Only 12 is supported; it sets the round-counter terminal value.

Ports:
- iclk  input  1  clock, rising edge.
- ireset  input  1  asynchronous, active-low reset.
- istart  input  1  start pulse. Samples ikey and idata. Ignored while obusy=1.
- ikey  input  [00:63]  cipher key; bit 0 is the MSB.
- idata  input  [00:63]  plaintext; bit 0 is the MSB.
- odata  output  [00:63]  ciphertext, held until the next accepted start.
- obusy  output  1  high while rounds are in progress.
- odone  output  1  one-cycle pulse when odata becomes valid.

Behaviour:
- Reset (ireset=0, any time, asynchronous): state, subkey, odata = 0; round = 0; obusy = 0; odone = 0; FSM goes to IDLE. Reset mid-encryption aborts the operation; no odone is produced.
- FSM states: IDLE and RUN.
  - IDLE with istart=1: state <= idata; sk <= ikey; round <= 1; obusy <= 1; go to RUN.
  - RUN: each cycle applies the round function and the key update (below), then round <= round+1.
  - RUN, on the edge that processes round 12: odata <= round12_out XOR KS(sk12, 12); odone <= 1 for one cycle; obusy <= 0; go to IDLE.
- Round function, applied in this order to 64-bit state s with subkey sk:
  1. AddRoundKey: s ^= sk.
  2. SubNibbles: 16 instances of klein_sbox, one per nibble [4i:4i+3].
  3. RotateNibbles: s <= {s[16:63], s[0:15]} (rotate left by 2 bytes).
  4. MixNibbles: AES MixColumns over GF(2^8), polynomial 0x11B, applied separately to bytes 0-3 and bytes 4-7.
- Key update KS(k, i), for i = 1..12:
  - Rotate each 32-bit half left by one byte.
  - Feistel step: new left = rotated right half; new right = rotated left XOR rotated right.
  - XOR {4'd0, i} into bits [16:23]. i is the 8-bit round index.
  - Pass bits [40:55] through klein_sbox, four nibbles.
- Subkey sequence: sk1 = ikey; sk(i+1) = KS(sk_i, i). Final whitening uses sk13.
- Latency: istart accepted at edge T; odone high in the cycle following edge T+12. odata is valid from that cycle onward.
- istart while obusy=1: ignored; the in-flight operation is unaffected.
- istart in the same cycle that odone is high: accepted (FSM is already IDLE). odata keeps its old value until the new completion.
- Back-to-back throughput: one block every 13 cycles.
- odone is never asserted without a preceding accepted istart since reset.

Test Plan:
- Key 0x0000000000000000, plaintext 0xFFFFFFFFFFFFFFFF -> odata 0xCDC0B51F14722BBE; odone high exactly 12 cycles after the start edge, one cycle wide.
- Key 0xFFFFFFFFFFFFFFFF, plaintext 0x0000000000000000 -> odata 0x6456764E8602E154.
- Key 0x1234567890ABCDEF, plaintext 0xFFFFFFFFFFFFFFFF -> odata 0x592356C4997176C8. Then key 0x0000000000000000, plaintext 0x1234567890ABCDEF -> odata 0x629F9D6DFF95800E.
- Start the first vector; pulse istart with different data at cycles 3 and 11 -> both ignored; the first result is unchanged and exactly one odone is produced.
- Start a vector; assert ireset at cycle 6 -> all outputs 0 immediately. Release and restart -> correct ciphertext after 12 cycles.
- Issue istart in the odone cycle -> second result correct 12 cycles later; the old odata is held in the interim.
